dr_mem_sequencer: RTL and testbench

- Sequences transfers between the 8-bit data register (DR) and data memory for the down-sampling processor.
- Arbitrates two requesters: the control unit (cu) and the image loader (ld).
- Generates the DR strobes (Write, Mem_Read, Read) and the memory address and write-enable.
- Round-robin grant; one transaction in flight at a time.

---
 rtl/dr_mem_sequencer_pkg.sv | 23 ++
 rtl/dr_mem_sequencer_rr_arb2.sv | 35 +++
 rtl/dr_mem_sequencer.sv | 144 ++++++++++++++
 tb/tb_dr_mem_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dr_mem_sequencer_pkg.sv
// Shared types and encodings for the DR / data-memory transfer sequencer.
package dr_mem_sequencer_pkg;

  // Sequencer states; IDLE must stay at encoding 0 so reset lands there.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_DR  = 3'd1,
    ST_MEM_WR = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_LATCH  = 3'd4,
    ST_OUT    = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Operation codes carried on op_cu / op_ld.
  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  // Owner encoding; also the arbiter request/grant bit index and bus_sel value.
  localparam logic OWN_CU = 1'b0;
  localparam logic OWN_LD = 1'b1;

endpackage

// File: rtl/dr_mem_sequencer_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from req and the
// remembered last winner; last winner only moves when the caller advances.
module rr_arb2
  import dr_mem_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_gnt_q;

  // Pick the single requester, or on contention the one that did not win last.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_gnt_q == OWN_LD) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Remember the winner of each accepted grant; ld is "last" out of reset so cu wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= OWN_LD;
    end else if (advance_i && (gnt_o != 2'b00)) begin
      last_gnt_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/dr_mem_sequencer.sv
// Sequences DR <-> data memory transfers for two requesters (cu, ld).
// One transaction in flight; all outputs are registers decoded from the
// next state, so nothing combinational runs from req/op/addr to an output.
module dr_mem_sequencer
  import dr_mem_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_cu,
  input  logic              op_cu,
  input  logic [ADDR_W-1:0] addr_cu,
  input  logic              req_ld,
  input  logic              op_ld,
  input  logic [ADDR_W-1:0] addr_ld,
  output logic              gnt_cu,
  output logic              gnt_ld,
  output logic              done_cu,
  output logic              done_ld,
  output logic              busy,
  output logic              bus_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              dr_write,
  output logic              dr_mem_read,
  output logic              dr_read
);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("dr_mem_sequencer: MEM_LAT must be >= 1");
  end

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         arb_gnt;
  logic               grant;

  // Registered outputs
  logic gnt_cu_q, gnt_ld_q, done_cu_q, done_ld_q, busy_q, bus_sel_q;
  logic mem_we_q, dr_write_q, dr_mem_read_q, dr_read_q;

  // Arbitration only takes effect while idle.
  assign grant = (state_q == ST_IDLE) && (arb_gnt != 2'b00);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({req_ld, req_cu}),
    .advance_i (state_q == ST_IDLE),
    .gnt_o     (arb_gnt)
  );

  // Next-state, latency counter and grant-time capture of owner/op/addr.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    op_d    = op_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = arb_gnt[1];
          op_d    = arb_gnt[1] ? op_ld   : op_cu;
          addr_d  = arb_gnt[1] ? addr_ld : addr_cu;
          state_d = (op_d == OP_STORE) ? ST_WR_DR : ST_MEM_RD;
        end
      end
      ST_WR_DR:  state_d = ST_MEM_WR;
      ST_MEM_WR: begin
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_MEM_RD: begin
        if (cnt_q == CNT_LAST) state_d = ST_LATCH;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_LATCH:  state_d = ST_OUT;
      ST_OUT:    state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Counter restarts from zero on every state change.
    if (state_d != state_q) cnt_d = '0;
  end

  // FSM state plus Moore strobes registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      owner_q       <= OWN_CU;
      op_q          <= OP_LOAD;
      addr_q        <= '0;
      gnt_cu_q      <= 1'b0;
      gnt_ld_q      <= 1'b0;
      done_cu_q     <= 1'b0;
      done_ld_q     <= 1'b0;
      busy_q        <= 1'b0;
      bus_sel_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      dr_write_q    <= 1'b0;
      dr_mem_read_q <= 1'b0;
      dr_read_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      gnt_cu_q      <= (state_d != ST_IDLE) && (owner_d == OWN_CU);
      gnt_ld_q      <= (state_d != ST_IDLE) && (owner_d == OWN_LD);
      done_cu_q     <= (state_d == ST_DONE) && (owner_d == OWN_CU);
      done_ld_q     <= (state_d == ST_DONE) && (owner_d == OWN_LD);
      busy_q        <= (state_d != ST_IDLE);
      bus_sel_q     <= (state_d == ST_WR_DR) && (owner_d == OWN_LD);
      mem_we_q      <= (state_d == ST_MEM_WR);
      dr_write_q    <= (state_d == ST_WR_DR);
      dr_mem_read_q <= (state_d == ST_LATCH);
      dr_read_q     <= (state_d == ST_OUT);
    end
  end

  assign gnt_cu      = gnt_cu_q;
  assign gnt_ld      = gnt_ld_q;
  assign done_cu     = done_cu_q;
  assign done_ld     = done_ld_q;
  assign busy        = busy_q;
  assign bus_sel     = bus_sel_q;
  assign mem_addr    = addr_q;
  assign mem_we      = mem_we_q;
  assign dr_write    = dr_write_q;
  assign dr_mem_read = dr_mem_read_q;
  assign dr_read     = dr_read_q;

endmodule

// File: tb/tb_dr_mem_sequencer.sv
// Directed bench for dr_mem_sequencer with MEM_LAT=2, plus a DR/memory model
// and a short random-traffic phase with invariant checks.
module tb_dr_mem_sequencer;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_cu = 1'b0, op_cu = 1'b0, req_ld = 1'b0, op_ld = 1'b0;
  logic [ADDR_W-1:0] addr_cu = '0, addr_ld = '0;
  logic              gnt_cu, gnt_ld, done_cu, done_ld, busy, bus_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, dr_write, dr_mem_read, dr_read;

  // DR / memory / bus model
  logic [7:0]  in_cu = '0, in_ld = '0;
  logic [7:0]  dr;
  logic [15:0] out_bus;
  logic [7:0]  mem [0:65535];

  int nvec = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  dr_mem_sequencer #(.ADDR_W(ADDR_W), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cu(req_cu), .op_cu(op_cu), .addr_cu(addr_cu),
    .req_ld(req_ld), .op_ld(op_ld), .addr_ld(addr_ld),
    .gnt_cu(gnt_cu), .gnt_ld(gnt_ld), .done_cu(done_cu), .done_ld(done_ld),
    .busy(busy), .bus_sel(bus_sel), .mem_addr(mem_addr), .mem_we(mem_we),
    .dr_write(dr_write), .dr_mem_read(dr_mem_read), .dr_read(dr_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[16'h0040] <= 8'hA5;
      dr            <= 8'h00;
      out_bus       <= 16'h0000;
    end else begin
      if (dr_write)    dr <= bus_sel ? in_ld : in_cu;
      if (dr_mem_read) dr <= mem[mem_addr];
      if (mem_we)      mem[mem_addr] <= dr;
      if (dr_read)     out_bus <= {8'h00, dr};
    end
  end

  function automatic logic [31:0] outs();
    return {6'd0, gnt_cu, gnt_ld, done_cu, done_ld, busy, bus_sel, mem_we,
            dr_write, dr_mem_read, dr_read, mem_addr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_cu = 1'b0; req_ld = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Invariants sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("strobe_onehot0", 32'($onehot0({dr_write, dr_mem_read, dr_read, mem_we})), 32'd1);
      chk("gnt_onehot0",    32'($onehot0({gnt_cu, gnt_ld})), 32'd1);
      chk("busy_vs_gnt",    32'(busy), 32'(gnt_cu | gnt_ld));
      chk("done_two",       32'(done_cu & done_ld), 32'd0);
    end
  end

  initial begin : stim
    logic [31:0] snap;
    int          cyc;
    int          ndone;
    logic        order [4];
    int          dcyc  [4];

    // ---------------- reset state
    rst_n = 1'b0;
    #2;
    chk("reset_outs", outs(), 32'd0);
    do_reset();
    chk("post_reset_idle", outs(), 32'd0);
    mon_en = 1'b1;

    // ---------------- 1: load cu from 0x0040
    req_cu = 1'b1; op_cu = 1'b0; addr_cu = 16'h0040;
    tick();                                           // t+1
    chk("ld1_gnt",     32'({gnt_cu, gnt_ld, busy}), 32'b101);
    chk("ld1_addr",    32'(mem_addr), 32'h0040);
    tick();                                           // t+2
    chk("ld1_t2_rd",   32'({dr_mem_read, dr_read}), 32'b00);
    tick();                                           // t+3
    chk("ld1_latch",   32'({dr_mem_read, dr_read, done_cu}), 32'b100);
    tick();                                           // t+4
    chk("ld1_out",     32'({dr_mem_read, dr_read, done_cu}), 32'b010);
    tick();                                           // t+5
    chk("ld1_done",    32'({done_cu, done_ld, gnt_cu}), 32'b101);
    chk("ld1_bus",     32'(out_bus), 32'h00A5);
    req_cu = 1'b0;
    tick();
    chk("ld1_idle",    32'({busy, gnt_cu, done_cu}), 32'b000);

    // ---------------- 2: store ld 0x5A to 0x1234
    req_ld = 1'b1; op_ld = 1'b1; addr_ld = 16'h1234; in_ld = 8'h5A; in_cu = 8'hFF;
    tick();                                           // t+1
    chk("st2_wrdr",    32'({dr_write, bus_sel, gnt_ld, mem_we}), 32'b1110);
    tick();                                           // t+2
    chk("st2_we1",     32'({mem_we, dr_write}), 32'b10);
    chk("st2_addr",    32'(mem_addr), 32'h1234);
    tick();                                           // t+3
    chk("st2_we2",     32'({mem_we, done_ld}), 32'b10);
    tick();                                           // t+4
    chk("st2_done",    32'({done_ld, done_cu, mem_we}), 32'b100);
    req_ld = 1'b0;
    tick();
    chk("st2_mem",     32'(mem[16'h1234]), 32'h5A);
    chk("st2_idle",    32'(busy), 32'd0);

    // ---------------- 3: both requests held continuously after reset
    do_reset();
    req_cu = 1'b1; op_cu = 1'b1; addr_cu = 16'h0010;
    req_ld = 1'b1; op_ld = 1'b1; addr_ld = 16'h0020;
    cyc = 0; ndone = 0;
    while (ndone < 4 && cyc < 60) begin
      tick(); cyc++;
      if (done_cu || done_ld) begin
        order[ndone] = done_ld;
        dcyc[ndone]  = cyc;
        ndone++;
      end
    end
    req_cu = 1'b0; req_ld = 1'b0;
    chk("rr_count", 32'(ndone), 32'd4);
    if (ndone == 4) begin
      chk("rr_first",  32'(order[0]), 32'd0);
      chk("rr_second", 32'(order[1]), 32'd1);
      chk("rr_third",  32'(order[2]), 32'd0);
      chk("rr_fourth", 32'(order[3]), 32'd1);
      chk("rr_lat0",   32'(dcyc[0]), 32'd4);
      for (int i = 1; i < 4; i++) chk("rr_gap", 32'(dcyc[i] - dcyc[i-1]), 32'd5);
    end
    tick(); tick();
    chk("rr_idle", 32'(busy), 32'd0);

    // ---------------- 4: reset during MEM_WR of a cu store
    req_cu = 1'b1; op_cu = 1'b1; addr_cu = 16'h0777; in_cu = 8'h33;
    tick();                                           // t+1 WR_DR
    tick();                                           // t+2 MEM_WR
    chk("rst_mid_we", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0; req_cu = 1'b0;
    #1;
    chk("rst_async_outs", outs(), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_nodone", 32'({done_cu, done_ld, busy}), 32'd0);
    end
    req_cu = 1'b1; op_cu = 1'b0; req_ld = 1'b1; op_ld = 1'b0;
    tick();
    chk("rst_cu_wins", 32'({gnt_cu, gnt_ld}), 32'b10);
    do_reset();

    // ---------------- 5: req dropped and addr changed mid-load
    req_cu = 1'b1; op_cu = 1'b0; addr_cu = 16'h0040;
    tick();                                           // t+1
    tick();                                           // t+2
    req_cu = 1'b0; addr_cu = 16'h0001; op_cu = 1'b1;
    tick();                                           // t+3
    chk("drop_addr",  32'(mem_addr), 32'h0040);
    chk("drop_latch", 32'(dr_mem_read), 32'd1);
    tick();                                           // t+4
    chk("drop_out",   32'(dr_read), 32'd1);
    tick();                                           // t+5
    chk("drop_done",  32'({done_cu, gnt_cu}), 32'b11);
    chk("drop_bus",   32'(out_bus), 32'h00A5);
    tick();
    chk("drop_idle",  32'({busy, gnt_cu, done_cu}), 32'd0);
    chk("drop_hold",  32'(mem_addr), 32'h0040);

    // ---------------- 6: random traffic, outputs must not move within a cycle
    for (int c = 0; c < 300; c++) begin
      if (done_cu) req_cu = 1'b0;
      else if (!req_cu && $urandom_range(1, 0) == 1) begin
        req_cu = 1'b1; op_cu = 1'($urandom_range(1, 0));
        addr_cu = 16'($urandom); in_cu = 8'($urandom);
      end
      if (done_ld) req_ld = 1'b0;
      else if (!req_ld && $urandom_range(1, 0) == 1) begin
        req_ld = 1'b1; op_ld = 1'($urandom_range(1, 0));
        addr_ld = 16'($urandom); in_ld = 8'($urandom);
      end
      snap = outs();
      #2;
      req_cu = ~req_cu; req_ld = ~req_ld;
      #1;
      chk("no_comb_path", outs(), snap);
      req_cu = ~req_cu; req_ld = ~req_ld;
      tick();
    end
    req_cu = 1'b0; req_ld = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("final_idle", 32'(busy), 32'd0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
